// File: rtl/bip_datapath_ext.sv
// BIP accumulator datapath: 8-function ALU, Z/N/C/V status,
// index register for indexed addressing and a serial shifter.
module bip_datapath_ext #(
  parameter int OPERAND_WIDTH = 11,
  parameter int DATA_WIDTH    = 16,
  parameter int SHAMT_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [OPERAND_WIDTH-1:0] operand_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [2:0]               alu_op_in,
  input  logic [1:0]               sel_A_in,
  input  logic                     sel_B_in,
  input  logic                     acc_wr_in,
  input  logic                     acc_reset_in,
  input  logic                     status_wr_in,
  input  logic                     status_reset_in,
  input  logic                     indr_wr_in,
  input  logic                     addr_mode_in,
  input  logic                     shift_start_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [OPERAND_WIDTH-1:0] data_address_out,
  output logic                     status_Z_out,
  output logic                     status_N_out,
  output logic                     status_C_out,
  output logic                     status_V_out,
  output logic                     shift_busy_out,
  output logic                     shift_done_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  indr_q, indr_d;
  logic                   z_q, z_d, n_q, n_d;
  logic                   c_q, c_d, v_q, v_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic                   fen_q, fen_d;
  logic                   ctmp_q, ctmp_d;

  logic [DATA_WIDTH-1:0]  ext_op;
  logic [DATA_WIDTH-1:0]  a_op;
  logic [DATA_WIDTH-1:0]  b_op;
  logic [DATA_WIDTH:0]    add_full;
  logic [DATA_WIDTH:0]    sub_full;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_c;
  logic                   alu_v;
  logic                   busy;
  logic                   start_ok;
  logic                   shift_fin;
  logic [DATA_WIDTH-1:0]  acc_src;

  assign ext_op = DATA_WIDTH'($signed(operand_in));
  assign a_op   = acc_q;
  assign b_op   = sel_B_in ? ext_op : data_in;

  assign busy      = (state_q == S_SHIFT);
  assign start_ok  = shift_start_in &&
                     (alu_op_in == OP_SLL || alu_op_in == OP_SRL);
  assign shift_fin = busy && (cnt_q == '0) && !acc_reset_in;

  // ALU: result plus carry/overflow for the arithmetic ops
  always_comb begin
    add_full = {1'b0, a_op} + {1'b0, b_op};
    sub_full = {1'b0, a_op} + {1'b0, ~b_op} + (DATA_WIDTH+1)'(1);
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    unique case (alu_op_in)
      OP_ADD: begin
        alu_res = add_full[DATA_WIDTH-1:0];
        alu_c   = add_full[DATA_WIDTH];
        alu_v   = (a_op[DATA_WIDTH-1] == b_op[DATA_WIDTH-1]) &&
                  (alu_res[DATA_WIDTH-1] != a_op[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[DATA_WIDTH-1:0];
        alu_c   = sub_full[DATA_WIDTH];
        alu_v   = (a_op[DATA_WIDTH-1] != b_op[DATA_WIDTH-1]) &&
                  (alu_res[DATA_WIDTH-1] != a_op[DATA_WIDTH-1]);
      end
      OP_AND: alu_res = a_op & b_op;
      OP_OR:  alu_res = a_op | b_op;
      OP_XOR: alu_res = a_op ^ b_op;
      OP_NOT: alu_res = ~a_op;
      OP_SLL: alu_res = a_op << b_op[SHAMT_WIDTH-1:0];
      OP_SRL: alu_res = a_op >> b_op[SHAMT_WIDTH-1:0];
    endcase
  end

  // Shifter next-state; an ACC clear always drops back to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = start_ok ? S_SHIFT : S_IDLE;
      S_SHIFT: state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
      S_DONE:  state_d = start_ok ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (acc_reset_in) state_d = S_IDLE;
  end

  // Shifter handshake outputs decoded from state
  always_comb begin
    shift_busy_out = 1'b0;
    shift_done_out = 1'b0;
    unique case (state_q)
      S_SHIFT: shift_busy_out = 1'b1;
      S_DONE:  shift_done_out = 1'b1;
      default: ;
    endcase
  end

  // Shifter datapath: capture on launch, one bit per cycle after
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fen_d   = fen_q;
    ctmp_d  = ctmp_q;
    if (!busy && start_ok) begin
      shreg_d = acc_q;
      cnt_d   = b_op[SHAMT_WIDTH-1:0];
      dir_d   = (alu_op_in == OP_SRL);
      fen_d   = status_wr_in;
      ctmp_d  = 1'b0;
    end else if (busy && cnt_q != '0) begin
      cnt_d = cnt_q - SHAMT_WIDTH'(1);
      if (dir_q) begin
        ctmp_d  = shreg_q[0];
        shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
      end else begin
        ctmp_d  = shreg_q[DATA_WIDTH-1];
        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // ACC source select and write priority
  always_comb begin
    acc_src = data_in;
    unique case (sel_A_in)
      2'b00: acc_src = data_in;
      2'b01: acc_src = ext_op;
      2'b10: acc_src = alu_res;
      2'b11: acc_src = indr_q;
    endcase
    acc_d = acc_q;
    if (acc_reset_in)            acc_d = '0;
    else if (shift_fin)          acc_d = shreg_q;
    else if (acc_wr_in && !busy) acc_d = acc_src;
  end

  // Status flags: clear, shifter completion, then ALU write
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    c_d = c_q;
    v_d = v_q;
    if (status_reset_in) begin
      z_d = 1'b0;
      n_d = 1'b0;
      c_d = 1'b0;
      v_d = 1'b0;
    end else if (shift_fin && fen_q) begin
      z_d = (shreg_q == '0);
      n_d = shreg_q[DATA_WIDTH-1];
      c_d = ctmp_q;
      v_d = 1'b0;
    end else if (status_wr_in && !busy) begin
      z_d = (alu_res == '0);
      n_d = alu_res[DATA_WIDTH-1];
      c_d = alu_c;
      v_d = alu_v;
    end
  end

  // INDR takes the pre-edge ACC whenever asked
  always_comb begin
    indr_d = indr_wr_in ? acc_q : indr_q;
  end

  // State registers
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      indr_q  <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fen_q   <= 1'b0;
      ctmp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      indr_q  <= indr_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fen_q   <= fen_d;
      ctmp_q  <= ctmp_d;
    end
  end

  assign data_out         = acc_q;
  assign data_address_out = addr_mode_in ?
                            operand_in + indr_q[OPERAND_WIDTH-1:0] :
                            operand_in;
  assign status_Z_out     = z_q;
  assign status_N_out     = n_q;
  assign status_C_out     = c_q;
  assign status_V_out     = v_q;

endmodule

// File: tb/tb_bip_datapath_ext.sv
// Randomised and directed bench for bip_datapath_ext against
// an arithmetic reference model of the datapath.
module tb_bip_datapath_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] operand;
  logic [15:0] din;
  logic [2:0]  op;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        acc_wr, acc_rst, st_wr, st_rst;
  logic        indr_wr, mode, start;
  logic [15:0] dout;
  logic [10:0] addr;
  logic        fz, fn, fc, fv, busy, done;

  int total = 0;
  int bad = 0;

  int unsigned m_acc, m_indr, m_res;
  bit          mz, mn, mc, mv, m_busy, m_done, m_fen, m_rc;
  longint      cyc = 0;
  longint      m_fin = 0;

  always #5 clk = ~clk;

  bip_datapath_ext dut (
    .clock_in(clk), .reset_in(rst),
    .operand_in(operand), .data_in(din),
    .alu_op_in(op), .sel_A_in(sel_a), .sel_B_in(sel_b),
    .acc_wr_in(acc_wr), .acc_reset_in(acc_rst),
    .status_wr_in(st_wr), .status_reset_in(st_rst),
    .indr_wr_in(indr_wr), .addr_mode_in(mode),
    .shift_start_in(start),
    .data_out(dout), .data_address_out(addr),
    .status_Z_out(fz), .status_N_out(fn),
    .status_C_out(fc), .status_V_out(fv),
    .shift_busy_out(busy), .shift_done_out(done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned sext(input logic [10:0] o);
    int v;
    v = (o >= 1024) ? int'(o) - 2048 : int'(o);
    return int'(unsigned'(v)) & 32'hFFFF;
  endfunction

  function automatic int sgn(input int unsigned x);
    return (x >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic alu(input int o, input int unsigned a,
                     input int unsigned b, output int unsigned r,
                     output bit c, output bit v);
    int unsigned s;
    int          t;
    c = 0;
    v = 0;
    case (o)
      0: begin
        s = a + b;
        r = s & 32'hFFFF;
        c = s[16];
        t = sgn(a) + sgn(b);
        v = (t > 32767) || (t < -32768);
      end
      1: begin
        s = a + ((~b) & 32'hFFFF) + 1;
        r = s & 32'hFFFF;
        c = s[16];
        t = sgn(a) - sgn(b);
        v = (t > 32767) || (t < -32768);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & 32'hFFFF;
      6: r = (a << (b % 16)) & 32'hFFFF;
      default: r = a >> (b % 16);
    endcase
  endtask

  task automatic model_zero();
    m_acc = 0; m_indr = 0; m_res = 0;
    mz = 0; mn = 0; mc = 0; mv = 0;
    m_busy = 0; m_done = 0; m_fen = 0; m_rc = 0;
  endtask

  task automatic check_outs();
    int unsigned ea;
    ea = mode ? ((operand + m_indr) & 32'h7FF) : operand;
    check("acc", dout, m_acc);
    check("flags", {fz, fn, fc, fv}, {mz, mn, mc, mv});
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("addr", addr, ea);
  endtask

  task automatic step();
    int unsigned b, r, na, ni, n;
    bit c, v, nb, nd;
    bit [3:0] fl;
    b  = sel_b ? sext(operand) : din;
    alu(op, m_acc, b, r, c, v);
    na = m_acc;
    ni = indr_wr ? m_acc : m_indr;
    nb = m_busy;
    nd = 0;
    fl = {mz, mn, mc, mv};
    if (m_busy) begin
      if (acc_rst) begin
        na = 0;
        nb = 0;
      end else if (cyc == m_fin) begin
        na = m_res;
        nb = 0;
        nd = 1;
        if (m_fen) fl = {m_res == 0, m_res[15], m_rc, 1'b0};
      end
      if (st_rst) fl = 0;
    end else begin
      if (acc_rst) na = 0;
      else if (acc_wr)
        case (sel_a)
          2'd0: na = din;
          2'd1: na = sext(operand);
          2'd2: na = r;
          default: na = m_indr;
        endcase
      if (st_rst) fl = 0;
      else if (st_wr) fl = {r == 0, r[15], c, v};
      if (start && (op == 6 || op == 7) && !acc_rst) begin
        n = b % 16;
        if (op == 6) begin
          m_res = (m_acc << n) & 32'hFFFF;
          m_rc  = (n == 0) ? 0 : m_acc[16-n];
        end else begin
          m_res = m_acc >> n;
          m_rc  = (n == 0) ? 0 : m_acc[n-1];
        end
        m_fen = st_wr;
        m_fin = cyc + n + 1;
        nb = 1;
      end
    end
    @(posedge clk);
    #1;
    if (rst) model_zero();
    else begin
      m_acc = na; m_indr = ni; m_busy = nb; m_done = nd;
      {mz, mn, mc, mv} = fl;
    end
    cyc++;
    check_outs();
  endtask

  task automatic idle_in();
    op = 0; sel_a = 0; sel_b = 0; acc_wr = 0; acc_rst = 0;
    st_wr = 0; st_rst = 0; indr_wr = 0; start = 0;
  endtask

  task automatic load(input logic [15:0] v);
    idle_in();
    din = v; sel_a = 0; acc_wr = 1;
    step();
    idle_in();
  endtask

  task automatic hit_reset();
    rst = 1;
    #1;
    model_zero();
    check_outs();
    check("rst_addr", addr, operand);
    step();
    rst = 0;
  endtask

  task automatic run_shift(input logic [2:0] o, input logic [10:0] amt,
                           input int pulse_at, output int nbusy,
                           output int ndone);
    idle_in();
    op = o; sel_b = 1; operand = amt; start = 1; st_wr = 1;
    step();
    nbusy = busy;
    ndone = 0;
    for (int i = 1; i < 20; i++) begin
      idle_in();
      if (i == pulse_at) begin
        acc_wr = 1; st_wr = 1; din = 16'hFFFF;
      end
      step();
      nbusy += busy;
      ndone += done;
    end
  endtask

  int nb, nd;

  initial begin
    idle_in();
    rst = 0; operand = 0; din = 0; mode = 0;
    model_zero();
    #2;
    load(16'h1234);
    operand = 11'h155;
    hit_reset();
    check("rst_acc", dout, 0);

    load(16'h7FFF);
    op = 0; sel_b = 1; operand = 11'h001; sel_a = 2;
    acc_wr = 1; st_wr = 1;
    step();
    check("add_res", dout, 16'h8000);
    check("add_flags", {fz, fn, fc, fv}, 4'b0101);
    op = 1; sel_b = 0; din = 16'h8000;
    step();
    check("sub_res", dout, 16'h0000);
    check("sub_flags", {fz, fn, fc, fv}, 4'b1010);

    idle_in();
    operand = 11'h7FF; sel_a = 1; acc_wr = 1;
    step();
    check("ext_ld", dout, 16'hFFFF);
    op = 5; sel_a = 2; st_wr = 1;
    step();
    check("not_res", dout, 16'h0000);
    check("not_flags", {fz, fn, fc, fv}, 4'b1000);

    load(16'h8001);
    run_shift(3'd6, 11'd3, 2, nb, nd);
    check("sll_acc", dout, 16'h0008);
    check("sll_c", fc, 0);
    check("sll_busy", nb, 4);
    check("sll_done", nd, 1);

    load(16'h8001);
    run_shift(3'd7, 11'd1, 0, nb, nd);
    check("srl_acc", dout, 16'h4000);
    check("srl_c", fc, 1);

    load(16'h8001);
    run_shift(3'd7, 11'd0, 0, nb, nd);
    check("sh0_acc", dout, 16'h8001);
    check("sh0_busy", nb, 1);

    load(16'h07FE);
    indr_wr = 1;
    step();
    idle_in();
    mode = 1; operand = 11'h003;
    #1;
    check("idx_addr", addr, 11'h001);
    mode = 0;
    #1;
    check("dir_addr", addr, 11'h003);

    load(16'h1234);
    op = 6; sel_b = 1; operand = 11'd15; start = 1;
    step();
    idle_in();
    nd = 0;
    for (int i = 1; i < 24; i++) begin
      acc_rst = (i == 5);
      step();
      nd += done;
    end
    check("abort_acc", dout, 0);
    check("abort_done", nd, 0);

    load(16'h1234);
    op = 6; sel_b = 1; operand = 11'd15; start = 1;
    step();
    idle_in();
    for (int i = 1; i < 5; i++) step();
    #2;
    hit_reset();
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      nd += done;
    end
    check("rst_done", nd, 0);

    for (int k = 0; k < 3000; k++) begin
      op      = 3'($urandom_range(0, 7));
      sel_a   = 2'($urandom_range(0, 3));
      sel_b   = 1'($urandom_range(0, 1));
      operand = 11'($urandom);
      din     = 16'($urandom);
      acc_wr  = 1'($urandom_range(0, 1));
      st_wr   = 1'($urandom_range(0, 1));
      acc_rst = ($urandom_range(0, 19) == 0);
      st_rst  = ($urandom_range(0, 19) == 0);
      indr_wr = ($urandom_range(0, 3) == 0);
      mode    = 1'($urandom_range(0, 1));
      start   = ($urandom_range(0, 2) == 0);
      if (k % 500 == 499) hit_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bip_datapath_ext.md
Name: bip_datapath_ext

Overview:
Parametrised next-generation accumulator datapath for the BIP processor family. It adds an 8-function ALU, a four-flag status register (Z/N/C/V) and an index register for indexed data addressing. It also adds a multi-cycle serial shifter with a busy/done handshake back to the control unit. It sits between the control unit, the instruction operand field and data memory.

Parameters:
OPERAND_WIDTH, 11, instruction operand / data address width
DATA_WIDTH, 16, accumulator, data bus and ALU width (>= OPERAND_WIDTH)
SHAMT_WIDTH, $clog2(DATA_WIDTH), width of shift-amount field

Ports:
clock_in  input  1  system clock, rising edge
reset_in  input  1  asynchronous, active-high; clears all state
operand_in  input  OPERAND_WIDTH  instruction operand
data_in  input  DATA_WIDTH  data-memory read data
alu_op_in  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SLL, 111 SRL
sel_A_in  input  2  ACC source: 00 data_in, 01 ext(operand), 10 ALU result, 11 INDR
sel_B_in  input  1  ALU B: 0 data_in, 1 ext(operand)
acc_wr_in  input  1  ACC write enable
acc_reset_in  input  1  synchronous ACC clear
status_wr_in  input  1  status write enable
status_reset_in  input  1  synchronous status clear
indr_wr_in  input  1  INDR <= ACC
addr_mode_in  input  1  0 direct, 1 indexed
shift_start_in  input  1  launch serial shift (alu_op SLL/SRL)
data_out  output  DATA_WIDTH  ACC value
data_address_out  output  OPERAND_WIDTH  data-memory address
status_Z_out, status_N_out, status_C_out, status_V_out  output  1 each  flags
shift_busy_out  output  1  shifter active
shift_done_out  output  1  one-cycle completion pulse

Behaviour:
- Reset state (reset_in=1, asynchronous): ACC, INDR, all flags, shifter registers, busy and done all 0.
- ext(operand) = operand_in sign-extended to DATA_WIDTH. A = ACC. B selected by sel_B_in.
- ADD: A+B; C = carry out; V = signed overflow.
- SUB: A+~B+1; C = carry out (1 = no borrow); V = signed overflow.
- AND/OR/XOR/NOT(~A): C and V cleared.
- Flags Z and N always derive from the value being written.
- ACC and status update on the rising edge; no combinational path from inputs to flags.
- Priority per edge, ACC: acc_reset_in > shifter completion > acc_wr_in.
- Priority per edge, status: status_reset_in > shifter completion > status_wr_in.
- INDR loads ACC (pre-edge value) on indr_wr_in, independent of the other enables.
- data_address_out is combinational:
  - direct: operand_in
  - indexed: (operand_in + INDR[OPERAND_WIDTH-1:0]) mod 2^OPERAND_WIDTH, wraps silently
- Shifter FSM, states IDLE / SHIFT / DONE:
  - IDLE: shift_start_in with alu_op SLL/SRL at edge E0 → capture SHREG=ACC, CNT=B[SHAMT_WIDTH-1:0], dir, flag_en=status_wr_in; busy=1; go SHIFT.
  - IDLE: shift_start_in with any other alu_op is ignored.
  - SHIFT, CNT>0: shift SHREG one bit (zero fill); C_tmp = bit shifted out; CNT--.
  - SHIFT, CNT==0: ACC<=SHREG; if flag_en, Z/N from SHREG, C=C_tmp, V=0; busy=0; done=1; go DONE.
  - DONE: done=0 next edge; return IDLE; a new start is accepted in this cycle.
  - Result: a shift by n writes ACC at edge E0+n+1; busy is high n+1 cycles.
  - Shift by 0: ACC unchanged, C_tmp=0.
- While busy:
  - acc_wr_in, status_wr_in and shift_start_in are ignored.
  - indr_wr_in still works, using the current ACC.
- acc_reset_in while busy aborts the shift: ACC=0, FSM IDLE, busy=0, no done pulse.
- reset_in mid-shift: immediate return to reset state; no done pulse.

Test Plan:
1. Assert reset_in mid-operation → all outputs 0 immediately, asynchronously; data_address_out = operand_in.
2. ACC=0x7FFF; ADD, sel_B=1, operand=0x001, sel_A=10, acc_wr, status_wr → ACC=0x8000, N=1, V=1, C=0, Z=0. Then SUB with data_in=0x8000, sel_B=0 → ACC=0x0000, Z=1, C=1, V=0.
3. operand=0x7FF, sel_A=01, acc_wr → ACC=0xFFFF. NOT with status_wr → ACC=0x0000, Z=1, C=0, V=0.
4. Shifts from ACC=0x8001:
   - SLL, operand=3, start, status_wr → busy 4 cycles; ACC=0x0008, C=0; done pulses exactly 1 cycle; acc_wr pulsed mid-shift has no effect.
   - SRL by 1 → ACC=0x4000, C=1.
   - Shift by 0 → busy 1 cycle, ACC unchanged.
5. ACC=0x07FE, indr_wr; addr_mode=1, operand=0x003 → data_address_out=0x001 (wrap). addr_mode=0 → 0x003.
6. SLL by 15 started; acc_reset_in at cycle 5 → ACC=0, busy=0, no done pulse. Repeat with reset_in → same result, asynchronously.
